imem_program_loader: RTL and testbench

- Writer side of the instruction-fetch path: receives a byte stream, assembles 32-bit instruction words and writes them into instruction memory from word address 0 upward.
- Holds the processor core in reset until a load completes with a valid checksum.
- Sits between a byte source (e.g. a UART receiver or test harness) and the instruction memory write port, beside the KGP-RISC top.

---
 rtl/imem_program_loader_pkg.sv | 35 +++
 rtl/imem_program_loader_word_assembler.sv | 37 +++
 rtl/imem_program_loader.sv | 206 ++++++++++++++++++++
 tb/tb_imem_program_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// FSM state encoding, checksum width and small helper functions.
package imem_program_loader_pkg;

  // Loader FSM states (encoding is fixed so debug tools can decode it).
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // Width of the running payload checksum (mod-256 byte sum).
  localparam int CSUM_W = 8;

  // Add one payload byte into the running checksum, wrapping mod 2**CSUM_W.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] sum,
                                                 input logic [7:0]        data);
    return sum + data;
  endfunction

  // States in which a load is in progress and bytes are accepted.
  function automatic logic is_busy(input state_e s);
    logic b;
    case (s)
      ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CSUM: b = 1'b1;
      default:                                b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_program_loader_word_assembler.sv
// Collects four stream bytes (MSB first) into one 32-bit instruction word.
// The word is presented combinationally together with the 4th byte so the
// caller can capture it on the same edge that accepts that byte.
module loader_word_assembler
  import imem_program_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_ready,
  output logic [31:0] o_word
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;

  // Byte index and shift register holding the first three bytes of a word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx   <= 2'd0;
      r_shift <= 24'h00_0000;
    end else if (i_clear) begin
      r_idx   <= 2'd0;
      r_shift <= 24'h00_0000;
    end else if (i_valid) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {r_shift[15:0], i_byte};
    end
  end

  // The 4th byte completes the word; it is appended without waiting a cycle.
  assign o_word_ready = i_valid && (r_idx == 2'd3);
  assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/imem_program_loader.sv
// Program loader: parses a byte stream (16-bit word count, 4N payload bytes,
// checksum byte), writes the payload words to instruction memory from word
// address 0 and releases the core reset only after a clean load.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  // Word-count limit widened so a 16-bit header compares without truncation.
  localparam logic [16:0] MAX_WORDS_L = 17'(MAX_WORDS);

  state_e              r_state;
  state_e              w_next_state;

  logic                r_byte_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_cpu_rst_n;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [31:0]         r_imem_wdata;

  logic [7:0]          r_count_hi;
  logic [15:0]         r_num_words;
  logic [15:0]         r_word_cnt;
  logic [CSUM_W-1:0]   r_sum;

  logic                w_xfer;
  logic                w_start_acc;
  logic [15:0]         w_hdr_n;
  logic                w_asm_valid;
  logic                w_word_ready;
  logic [31:0]         w_word;
  logic                w_last_word;

  logic                w_byte_ready_d;
  logic                w_busy_d;
  logic                w_done_d;
  logic                w_err_d;
  logic                w_cpu_rst_n_d;

  // A byte moves only when the registered ready meets a valid byte.
  assign w_xfer      = i_byte_valid && r_byte_ready;
  // start is honoured only outside a load.
  assign w_start_acc = i_start && !is_busy(r_state);
  // Full word count as seen while the low header byte is on the bus.
  assign w_hdr_n     = {r_count_hi, i_byte_data};
  assign w_asm_valid = w_xfer && (r_state == ST_DATA);
  // N >= 1 whenever we are in DATA, so N-1 cannot underflow there.
  assign w_last_word = (r_word_cnt == (r_num_words - 16'd1));

  loader_word_assembler u_asm (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (w_start_acc),
    .i_valid      (w_asm_valid),
    .i_byte       (i_byte_data),
    .o_word_ready (w_word_ready),
    .o_word       (w_word)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next_state = ST_HDR_HI;
        else         w_next_state = ST_IDLE;
      end
      ST_HDR_HI: begin
        if (w_xfer) w_next_state = ST_HDR_LO;
        else        w_next_state = ST_HDR_HI;
      end
      ST_HDR_LO: begin
        if (!w_xfer)                            w_next_state = ST_HDR_LO;
        else if (w_hdr_n == 16'd0)              w_next_state = ST_CSUM;
        else if ({1'b0, w_hdr_n} > MAX_WORDS_L) w_next_state = ST_ERR;
        else                                    w_next_state = ST_DATA;
      end
      ST_DATA: begin
        if (w_word_ready && w_last_word) w_next_state = ST_CSUM;
        else                             w_next_state = ST_DATA;
      end
      ST_CSUM: begin
        if (!w_xfer)                    w_next_state = ST_CSUM;
        else if (i_byte_data == r_sum)  w_next_state = ST_DONE;
        else                            w_next_state = ST_ERR;
      end
      ST_DONE: begin
        if (i_start) w_next_state = ST_HDR_HI;
        else         w_next_state = ST_DONE;
      end
      ST_ERR: begin
        if (i_start) w_next_state = ST_HDR_HI;
        else         w_next_state = ST_ERR;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM output decode, computed from the next state so outputs can be registered
  // and line up with the cycle in which the new state is current.
  always_comb begin
    w_byte_ready_d = is_busy(w_next_state);
    w_busy_d       = is_busy(w_next_state);
    w_done_d       = (w_next_state == ST_DONE);
    w_err_d        = (w_next_state == ST_ERR);
    // Release the core only once DONE has been current for a full cycle;
    // a start issued from DONE therefore drops it on the very next edge.
    w_cpu_rst_n_d  = (r_state == ST_DONE) && (w_next_state == ST_DONE);
  end

  // Registered status and handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cpu_rst_n  <= 1'b0;
    end else begin
      r_byte_ready <= w_byte_ready_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_err        <= w_err_d;
      r_cpu_rst_n  <= w_cpu_rst_n_d;
    end
  end

  // Header capture, checksum, word counter and memory write port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count_hi   <= 8'h00;
      r_num_words  <= 16'h0000;
      r_word_cnt   <= 16'h0000;
      r_sum        <= {CSUM_W{1'b0}};
      r_imem_we    <= 1'b0;
      r_imem_addr  <= {ADDR_W{1'b0}};
      r_imem_wdata <= 32'h0000_0000;
    end else if (w_start_acc) begin
      r_word_cnt   <= 16'h0000;
      r_sum        <= {CSUM_W{1'b0}};
      r_imem_we    <= 1'b0;
      r_imem_addr  <= {ADDR_W{1'b0}};
    end else begin
      // One-cycle strobe for every completed word.
      r_imem_we <= w_word_ready;
      if ((r_state == ST_HDR_HI) && w_xfer) begin
        r_count_hi <= i_byte_data;
      end
      if ((r_state == ST_HDR_LO) && w_xfer) begin
        r_num_words <= w_hdr_n;
      end
      if (w_asm_valid) begin
        r_sum <= csum_add(r_sum, i_byte_data);
      end
      if (w_word_ready) begin
        r_imem_wdata <= w_word;
        r_word_cnt   <= r_word_cnt + 16'd1;
      end
      // Address advances on the edge after the strobe, so it is stable
      // while imem_we is high.
      if (r_imem_we) begin
        r_imem_addr <= r_imem_addr + ADDR_W'(1);
      end
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_cpu_rst_n  = r_cpu_rst_n;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: a table of per-cycle input and
// expected-output records, followed by a hand-written random-valid payload
// phase that ends with an asynchronous reset in the middle of a load.
module tb_imem_program_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  imem_program_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_byte_valid (byte_valid),
    .i_byte_data  (byte_data),
    .o_byte_ready (byte_ready),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_cpu_rst_n  (cpu_rst_n),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output layout: {ready, we, addr[9:0], wdata[31:0], busy, done, err, cpu_rst_n}
  typedef struct packed {
    logic        s;
    logic        v;
    logic [7:0]  d;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs[80];
  int   nv;
  int   n_vec;
  int   n_bad;

  localparam logic [31:0] W0 = 32'h2001_0005;
  localparam logic [31:0] W1 = 32'h8C22_0004;
  localparam logic [31:0] WR = 32'h1122_3344;

  function automatic logic [47:0] outs();
    return {byte_ready, imem_we, imem_addr, imem_wdata, busy, done, err, cpu_rst_n};
  endfunction

  task automatic cmp(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got rdy=%b we=%b addr=%0d wdata=%h busy=%b done=%b err=%b cpu=%b, want rdy=%b we=%b addr=%0d wdata=%h busy=%b done=%b err=%b cpu=%b",
               name, act[47], act[46], act[45:36], act[35:4], act[3], act[2], act[1], act[0],
               exp[47], exp[46], exp[45:36], exp[35:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic s, input logic v, input logic [7:0] d,
                     input logic r, input logic we, input logic [9:0] a, input logic [31:0] wd,
                     input logic b, input logic dn, input logic er, input logic c);
    vecs[nv] = '{s: s, v: v, d: d, exp: {r, we, a, wd, b, dn, er, c}};
    nv = nv + 1;
  endtask

  // Appends the two-word stream 00 02 | 20 01 00 05 | 8C 22 00 04 | csum.
  // Payload sum mod 256 is 0x20+0x01+0x05+0x8C+0x22+0x04 = 0xD8.
  // wd_prev is the wdata still held from before this load.
  task automatic add_stream(input logic [7:0] csum, input logic [31:0] wd_prev, input logic good);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, wd_prev, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 10'd0, wd_prev, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 10'd0, wd_prev, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 10'd0, wd_prev, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, wd_prev, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 10'd0, W0,      1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h8C, 1'b1, 1'b0, 10'd1, W0,      1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 10'd1, W0,      1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd1, W0,      1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 10'd1, W1,      1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, csum,  1'b0, 1'b0, 10'd2, W1,      1'b0, good, ~good, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'd2, W1,      1'b0, good, ~good, good);
  endtask

  logic [7:0] payload[5];

  initial begin
    int   k;
    logic exp_we;
    logic v;

    n_vec = 0;
    n_bad = 0;
    nv    = 0;
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    payload[3] = 8'h44; payload[4] = 8'h55;

    // ---- idle after reset ----
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    // ---- good two-word load ----
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_stream(8'hD8, 32'h0, 1'b1);
    // byte_valid with ready low is ignored
    add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 10'd2, W1, 1'b0, 1'b1, 1'b0, 1'b1);
    // ---- same stream, bad checksum ----
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, W1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_stream(8'hD9, W1, 1'b0);
    // ---- oversize header 0x0401 ----
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, W1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 10'd0, W1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 10'd0, W1, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 10'd0, W1, 1'b0, 1'b0, 1'b1, 1'b0);
    // ---- empty program: header 0000, checksum 00 ----
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, W1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, W1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, W1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 10'd0, W1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'd0, W1, 1'b0, 1'b1, 1'b0, 1'b1);
    // restart from DONE: core reset drops on the next cycle
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, W1, 1'b1, 1'b0, 1'b0, 1'b0);
    // start while busy is ignored
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, W1, 1'b1, 1'b0, 1'b0, 1'b0);
    // ---- header exactly MAX_WORDS (0x0400) is accepted ----
    add(1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 10'd0, W1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, W1, 1'b1, 1'b0, 1'b0, 1'b0);

    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #12;
    cmp("reset_values", outs(), {1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table phase ----
    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      start      = vecs[i].s;
      byte_valid = vecs[i].v;
      byte_data  = vecs[i].d;
      @(posedge clk);
      #1;
      cmp($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // ---- payload with random valid gaps, then async reset ----
    k      = 0;
    exp_we = 1'b0;
    for (int cyc = 0; cyc < 200 && k < 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (exp_we)
        cmp("rand_word_write", outs(), {1'b1, 1'b1, 10'd0, WR, 1'b1, 1'b0, 1'b0, 1'b0});
      else
        cmp("rand_no_write", {byte_ready, imem_we, busy, cpu_rst_n},
            {44'h0, 1'b1, 1'b0, 1'b1, 1'b0});
      v          = 1'($urandom_range(0, 1));
      byte_valid = v;
      byte_data  = payload[k];
      exp_we     = v && (k == 3);
      if (v) k = k + 1;
    end
    if (k < 5) cmp("rand_timeout", 48'(k), 48'd5);
    @(negedge clk);
    byte_valid = 1'b0;
    cmp("rand_after_5th", outs(), {1'b1, 1'b0, 10'd1, WR, 1'b1, 1'b0, 1'b0, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_reset", outs(), {1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = 8'hA0 + 8'(i);
      @(posedge clk);
      #1;
      cmp("in_reset", outs(), {1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      cmp("post_reset_idle", outs(), {1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
